// File: rtl/ibex_pkg.sv
// ----------------------------------------------------------------------------
// ibex_pkg
//   Shared constants for the instruction prefetch path. The fetch request
//   controller and the fetch FIFO must agree on how many bus requests may be
//   in flight, so both take their default from FETCH_NUM_REQS.
// ----------------------------------------------------------------------------
package ibex_pkg;

  localparam int unsigned FETCH_NUM_REQS = 2;

endpackage

// File: rtl/ibex_fetch_req_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_fetch_req_ctrl
//   Request side of the instruction fetch path. Issues word-aligned fetches on
//   the req/gnt/rvalid instruction bus, tracks up to NUM_REQS outstanding
//   responses, discards responses made stale by a branch and pushes the
//   surviving responses into the fetch FIFO.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i                  fetching enabled
//   branch_i, addr_i       redirect fetch to addr_i (halfword aligned)
//   busy_o                 request pending or any response outstanding
//   fifo_clear_o           FIFO clear (asserted with branch_i)
//   fifo_busy_i            FIFO upper-entry occupancy
//   fifo_valid_o           push current response into the FIFO
//   fifo_addr_o            FIFO input address (branch target)
//   fifo_rdata_o/err_o     FIFO input data / error (bus pass-through)
//   instr_req_o/gnt_i      bus request / grant
//   instr_addr_o           bus address, always word aligned
//   instr_rvalid_i         in-order response valid
//   instr_rdata_i/err_i    response data / error
// ----------------------------------------------------------------------------
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = FETCH_NUM_REQS,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MAX_OUT = cnt_t'(NUM_REQS);

  function automatic cnt_t count_ones(input logic [NUM_REQS-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

  logic [NUM_REQS-1:0] out_q, out_d, disc_q, disc_d;
  logic [NUM_REQS-1:0] out_shift, disc_shift;
  logic                valid_req_q, valid_req_d;
  logic                discard_req_q, discard_req_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         stored_addr_q;
  logic [31:0]         branch_addr;
  cnt_t                out_cnt, fifo_cnt, slot;
  logic [CNT_W:0]      occupancy;
  logic                new_req, gnt_req, gnt_disc, retire, store_en;

  assign branch_addr = {addr_i[31:2], 2'b00};
  assign out_cnt     = count_ones(out_q);
  assign fifo_cnt    = count_ones(fifo_busy_i);
  assign occupancy   = {1'b0, fifo_cnt} + {1'b0, out_cnt};

  // A branch clears the FIFO in the same cycle, so its occupancy is ignored;
  // the bus-side outstanding limit always applies.
  assign new_req = req_i & (branch_i | (occupancy < {1'b0, MAX_OUT})) & (out_cnt < MAX_OUT);

  // Once presented, an ungranted request is replayed from the stored copy so
  // the bus sees a stable request/address regardless of req_i or branch_i.
  assign instr_req_o  = valid_req_q | new_req;
  assign instr_addr_o = valid_req_q ? stored_addr_q : (branch_i ? branch_addr : fetch_addr_q);

  assign gnt_req     = instr_req_o & instr_gnt_i;
  assign valid_req_d = instr_req_o & ~instr_gnt_i;
  // Only a replayed request can target the pre-branch address.
  assign gnt_disc      = valid_req_q & (discard_req_q | branch_i);
  assign discard_req_d = valid_req_d & gnt_disc;
  assign store_en      = instr_req_o & ~valid_req_q;

  // Retire only a tracked entry, so an illegal stray rvalid cannot underflow.
  assign retire = instr_rvalid_i & out_q[0];

  always_comb begin
    out_shift  = retire ? (out_q >> 1) : out_q;
    disc_shift = retire ? (disc_q >> 1) : disc_q;
    slot       = out_cnt - cnt_t'(retire);
    out_d      = out_shift;
    // Everything already in flight belongs to the old stream on a branch.
    disc_d     = branch_i ? (disc_shift | out_shift) : disc_shift;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (gnt_req && (cnt_t'(i) == slot)) begin
        out_d[i]  = 1'b1;
        disc_d[i] = gnt_disc;
      end
    end
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      // A fresh request granted this cycle already fetched the target word.
      fetch_addr_d = (gnt_req & ~valid_req_q) ? branch_addr + 32'd4 : branch_addr;
    end else if (gnt_req & ~gnt_disc) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q         <= '0;
      disc_q        <= '0;
      valid_req_q   <= 1'b0;
      discard_req_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      disc_q        <= disc_d;
      valid_req_q   <= valid_req_d;
      discard_req_q <= discard_req_d;
    end
  end

  if (ResetAll) begin : g_addr_reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fetch_addr_q  <= '0;
        stored_addr_q <= '0;
      end else begin
        fetch_addr_q <= fetch_addr_d;
        if (store_en) begin
          stored_addr_q <= instr_addr_o;
        end
      end
    end
  end else begin : g_addr_noreset
    always_ff @(posedge clk_i) begin
      fetch_addr_q <= fetch_addr_d;
      if (store_en) begin
        stored_addr_q <= instr_addr_o;
      end
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign busy_o       = instr_req_o | (|out_q);

  a_max_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_cnt <= MAX_OUT);
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> out_q[0]);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o & ~instr_gnt_i) |=> (instr_req_o & $stable(instr_addr_o)));
  a_fifo_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_valid_o |-> ~(&fifo_busy_i));
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
module tb_ibex_fetch_req_ctrl;

  localparam int N = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, branch_i;
  logic [31:0]   addr_i;
  logic          busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [N-1:0]  fifo_busy_i;
  logic [31:0]   fifo_addr_o, fifo_rdata_o;
  logic          instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0]   instr_addr_o, instr_rdata_i;

  ibex_fetch_req_ctrl #(.NUM_REQS(N), .ResetAll(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .fifo_clear_o(fifo_clear_o), .fifo_busy_i(fifo_busy_i),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: in-flight responses as a queue of {address, stale},
  // plus the one request the bus is currently holding ungranted.
  typedef struct { logic [31:0] addr; bit disc; } ent_t;
  ent_t        m_q[$];
  bit          m_held, m_held_disc;
  logic [31:0] m_held_addr, m_fetch;
  logic [31:0] pushed[$];
  logic [31:0] mem_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        last_req, last_valid, last_err, last_clear, last_busy;
  logic [31:0] last_addr, last_faddr;
  bit          last_granted;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_q.delete(); mem_q.delete();
    m_held = 0; m_held_disc = 0; m_held_addr = '0; m_fetch = '0;
  endtask

  task automatic drive_cycle(input bit req, input bit br, input logic [31:0] ba, input bit gnt,
                             input bit rv, input logic [N-1:0] fb, input bit err, input string tag);
    bit          exp_req, exp_valid, exp_busy, was_held, granted, g_disc, new_hdisc;
    logic [31:0] exp_addr, tgt, exp_rdata;
    int          occ;
    @(negedge clk_i);
    req_i = req; branch_i = br; addr_i = ba; instr_gnt_i = gnt; instr_rvalid_i = rv;
    fifo_busy_i = fb; instr_err_i = err;
    instr_rdata_i = (rv && mem_q.size() > 0) ? mem_word(mem_q[0]) : 32'h0;
    #1;
    tgt       = {ba[31:2], 2'b00};
    occ       = $countones(fb) + m_q.size();
    exp_req   = m_held || (req && (br || occ < N) && m_q.size() < N);
    exp_addr  = m_held ? m_held_addr : (br ? tgt : m_fetch);
    exp_valid = rv && (m_q.size() > 0) && !m_q[0].disc && !br;
    exp_rdata = (m_q.size() > 0) ? mem_word(m_q[0].addr) : 32'h0;
    exp_busy  = exp_req || (m_q.size() > 0);

    n_checks++;
    if (instr_req_o !== exp_req) begin
      n_fail++; $display("FAIL %s instr_req: got %0b expected %0b", tag, instr_req_o, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (instr_addr_o !== exp_addr) begin
        n_fail++; $display("FAIL %s instr_addr: got %h expected %h", tag, instr_addr_o, exp_addr);
      end
    end
    n_checks++;
    if (fifo_valid_o !== exp_valid) begin
      n_fail++; $display("FAIL %s fifo_valid: got %0b expected %0b", tag, fifo_valid_o, exp_valid);
    end
    if (exp_valid) begin
      n_checks++;
      if (fifo_rdata_o !== exp_rdata || fifo_err_o !== err) begin
        n_fail++; $display("FAIL %s fifo_data: got %h/%0b expected %h/%0b", tag, fifo_rdata_o, fifo_err_o, exp_rdata, err);
      end
    end
    n_checks++;
    if (busy_o !== exp_busy) begin
      n_fail++; $display("FAIL %s busy: got %0b expected %0b", tag, busy_o, exp_busy);
    end
    n_checks++;
    if (fifo_clear_o !== br || (br && fifo_addr_o !== ba)) begin
      n_fail++; $display("FAIL %s clear/addr: got %0b/%h expected %0b/%h", tag, fifo_clear_o, fifo_addr_o, br, ba);
    end

    last_req = instr_req_o; last_addr = instr_addr_o; last_valid = fifo_valid_o;
    last_err = fifo_err_o; last_clear = fifo_clear_o; last_faddr = fifo_addr_o;
    last_busy = busy_o; last_granted = instr_req_o && gnt;

    if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if (instr_req_o && gnt) mem_q.push_back(instr_addr_o);

    was_held  = m_held;
    granted   = exp_req && gnt;
    g_disc    = was_held && (m_held_disc || br);
    new_hdisc = was_held ? (m_held_disc || br) : 1'b0;
    if (exp_valid) pushed.push_back(m_q[0].addr);
    if (rv && m_q.size() > 0) void'(m_q.pop_front());
    if (br) foreach (m_q[i]) m_q[i].disc = 1;
    if (granted) m_q.push_back('{addr: exp_addr, disc: g_disc});
    if (br) m_fetch = (granted && !was_held) ? tgt + 32'd4 : tgt;
    else if (granted && !g_disc) m_fetch = m_fetch + 32'd4;
    if (exp_req && !gnt) begin
      m_held = 1; m_held_addr = exp_addr; m_held_disc = new_hdisc;
    end else begin
      m_held = 0; m_held_disc = 0;
    end
  endtask

  task automatic drain(input logic [N-1:0] fb, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!m_held && m_q.size() == 0) break;
      drive_cycle(0, 0, 32'h0, 1, m_q.size() > 0, fb, 0, tag);
    end
    drive_cycle(0, 0, 32'h0, 0, 0, fb, 0, tag);
    n_checks++;
    if (last_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s drain_idle: busy got %0b expected 0", tag, last_busy);
    end
  endtask

  task automatic check_push(input int idx, input logic [31:0] exp, input string tag);
    n_checks++;
    if (pushed.size() <= idx) begin
      n_fail++; $display("FAIL %s push[%0d]: got none expected %h", tag, idx, exp);
    end else if (pushed[idx] !== exp) begin
      n_fail++; $display("FAIL %s push[%0d]: got %h expected %h", tag, idx, pushed[idx], exp);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; req_i = 0; branch_i = 0; addr_i = '0; instr_gnt_i = 0; instr_rvalid_i = 0;
    fifo_busy_i = '0; instr_err_i = 0; instr_rdata_i = '0;
    model_reset();
    #3;
    n_checks++;
    if ({instr_req_o, busy_o, fifo_valid_o, fifo_clear_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {instr_req_o, busy_o, fifo_valid_o, fifo_clear_o});
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] issued[$];
    pushed.delete();
    drive_cycle(1, 1, 32'h100, 1, 0, '0, 0, "t1");
    if (last_granted) issued.push_back(last_addr);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, 32'h0, 1, m_q.size() > 0, '0, 0, "t1");
      if (last_granted) issued.push_back(last_addr);
    end
    drain('0, "t1");
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (issued.size() <= k || issued[k] !== 32'h100 + 32'(4 * k)) begin
        n_fail++; $display("FAIL t1_issue[%0d]: got %h expected %h", k,
                           (issued.size() > k) ? issued[k] : 32'hx, 32'h100 + 32'(4 * k));
      end
      check_push(k, 32'h100 + 32'(4 * k), "t1");
    end
  endtask

  task automatic test_branch_outputs();
    drive_cycle(1, 1, 32'h202, 1, 0, '0, 0, "t2");
    n_checks++;
    if (last_addr !== 32'h200 || last_clear !== 1'b1 || last_faddr !== 32'h202) begin
      n_fail++; $display("FAIL t2_branch: got addr %h clr %0b faddr %h expected 200 1 202", last_addr, last_clear, last_faddr);
    end
    drain('0, "t2");
  endtask

  task automatic test_branch_discard();
    drive_cycle(1, 1, 32'h100, 1, 0, '0, 0, "t3");
    drive_cycle(1, 0, 32'h0, 1, 0, '0, 0, "t3");
    pushed.delete();
    drive_cycle(1, 1, 32'h400, 1, 0, '0, 0, "t3");
    n_checks++;
    if (last_req !== 1'b0) begin
      n_fail++; $display("FAIL t3_full_req: got %0b expected 0", last_req);
    end
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, 32'h0, 1, m_q.size() > 0, '0, 0, "t3");
    drain('0, "t3");
    check_push(0, 32'h400, "t3");
  endtask

  task automatic test_held_request();
    drive_cycle(1, 1, 32'h100, 1, 0, '0, 0, "t4");
    drive_cycle(1, 0, 32'h0, 1, 1, '0, 0, "t4");
    drive_cycle(1, 0, 32'h0, 0, 1, '0, 0, "t4");
    drive_cycle(1, 0, 32'h0, 0, 0, '0, 0, "t4");
    pushed.delete();
    drive_cycle(1, 1, 32'h300, 0, 0, '0, 0, "t4");
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h108) begin
      n_fail++; $display("FAIL t4_hold: got req %0b addr %h expected 1 108", last_req, last_addr);
    end
    drive_cycle(1, 0, 32'h0, 1, 0, '0, 0, "t4");
    n_checks++;
    if (last_addr !== 32'h108) begin
      n_fail++; $display("FAIL t4_gnt_addr: got %h expected 108", last_addr);
    end
    drive_cycle(1, 0, 32'h0, 1, 1, '0, 0, "t4");
    n_checks++;
    if (last_addr !== 32'h300 || last_valid !== 1'b0) begin
      n_fail++; $display("FAIL t4_redirect: got addr %h valid %0b expected 300 0", last_addr, last_valid);
    end
    drain('0, "t4");
    check_push(0, 32'h300, "t4");
  endtask

  task automatic test_fifo_capacity();
    int grants = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 32'h0, 1, 0, 2'b11, 0, "t5");
      n_checks++;
      if (last_req !== 1'b0) begin
        n_fail++; $display("FAIL t5_full: got req %0b expected 0", last_req);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, 32'h0, 1, 0, 2'b01, 0, "t5");
      if (last_granted) grants++;
    end
    n_checks++;
    if (grants != 1) begin
      n_fail++; $display("FAIL t5_one_slot: got %0d requests expected 1", grants);
    end
    drain(2'b01, "t5");
  endtask

  task automatic test_err_and_async_reset();
    pushed.delete();
    drive_cycle(1, 1, 32'h500, 1, 0, '0, 0, "t6");
    drive_cycle(1, 0, 32'h0, 1, 1, '0, 1, "t6");
    n_checks++;
    if (last_valid !== 1'b1 || last_err !== 1'b1) begin
      n_fail++; $display("FAIL t6_err: got valid %0b err %0b expected 1 1", last_valid, last_err);
    end
    check_push(0, 32'h500, "t6");
    drive_cycle(1, 0, 32'h0, 0, 1, '0, 0, "t6");
    @(negedge clk_i);
    req_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_err_i = 0;
    #2 rst_ni = 0;
    #1;
    n_checks++;
    if ({instr_req_o, busy_o, fifo_valid_o, fifo_clear_o} !== 4'b0000) begin
      n_fail++; $display("FAIL t6_async_reset: got %b expected 0000", {instr_req_o, busy_o, fifo_valid_o, fifo_clear_o});
    end
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    pushed.delete();
    drive_cycle(1, 1, 32'h600, 1, 0, '0, 0, "t6");
    drive_cycle(1, 0, 32'h0, 0, 1, '0, 0, "t6");
    drain('0, "t6");
    check_push(0, 32'h600, "t6");
  endtask

  task automatic test_wrap();
    pushed.delete();
    drive_cycle(1, 1, 32'hFFFF_FFFA, 1, 0, '0, 0, "wrap");
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 32'h0, 1, m_q.size() > 0, '0, 0, "wrap");
    drain('0, "wrap");
    check_push(0, 32'hFFFF_FFF8, "wrap");
    check_push(1, 32'hFFFF_FFFC, "wrap");
    check_push(2, 32'h0000_0000, "wrap");
  endtask

  task automatic test_random();
    bit          req, br, gnt, rv, err;
    logic [31:0] ba;
    logic [N-1:0] fb;
    drive_cycle(1, 1, 32'h1000, 1, 0, '0, 0, "rand");
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 9) < 8);
      br  = ($urandom_range(0, 9) == 0);
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hE)) : ($urandom & 32'hFFFF_FFFE);
      gnt = ($urandom_range(0, 9) < 6);
      rv  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      fb  = N'($urandom_range(0, 3));
      if (&fb && rv) fb = 2'b01;
      err = ($urandom_range(0, 7) == 0);
      drive_cycle(req, br, ba, gnt, rv, fb, err, "rand");
    end
    drain('0, "rand");
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_branch_outputs();
    test_branch_discard();
    test_held_request();
    test_fifo_capacity();
    test_err_and_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
